// File: rtl/uart_pkg.sv
// uart_pkg: shared RX state encoding, default bit timing and loader error codes
package uart_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    START = ST_START,
    DATA = ST_DATA,
    STOP = ST_STOP
  } rx_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [7:0] ERR_FRAME = 8'h01;
  localparam logic [7:0] ERR_OVERRUN = 8'h02;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO, head is mem[rd_ptr] (not registered ahead)
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge CLK)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_byte_io.sv
// uart_rx_byte_io: 8N1 UART receiver feeding a byte FIFO read via req/ready/done
import uart_pkg::*;
module uart_rx_byte_io #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       io_read_req,
  output logic       io_ready,
  output logic       io_done,
  output logic [7:0] io_rdata,
  output logic       frame_err,
  output logic       overrun_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  logic [1:0] sync;
  logic rx;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic push, stop_bad, accept, empty, full;
  logic [7:0] head;
  assign rx = sync[1];
  assign io_ready = !empty && !io_done;
  assign accept = io_read_req && io_ready;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RST(RST), .push(push), .push_data(shift),
    .pop(accept), .head(head), .empty(empty), .full(full)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    push = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx ? IDLE : START;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_n = '0;
        shift_n[idx] = rx;
        idx_n = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_n = '0;
        push = rx;
        stop_bad = !rx;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      io_done <= 1'b0;
      io_rdata <= '0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync <= {sync[0], RXD};
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      io_done <= accept;
      if (accept) io_rdata <= head;
      frame_err <= frame_err | stop_bad;
      overrun_err <= overrun_err | (push && full);
    end
  end
endmodule

// File: tb/tb_uart_rx_byte_io.sv
// tb_uart_rx_byte_io: directed tests of the UART receiver and byte-read handshake
module tb_uart_rx_byte_io;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RXD = 1'b1;
  logic io_read_req = 1'b0;
  logic io_ready, io_done, frame_err, overrun_err;
  logic [7:0] io_rdata;
  int checks = 0;
  int failures = 0;
  logic [7:0] stream [10] = '{8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};

  uart_rx_byte_io #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .io_read_req(io_read_req),
    .io_ready(io_ready), .io_done(io_done), .io_rdata(io_rdata),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (16) @(negedge CLK);
    end
    RXD = stop;
    repeat (16) @(negedge CLK);
    RXD = 1'b1;
  endtask

  // ok is set only if io_done pulsed for exactly one cycle after the request
  task automatic read_byte(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 2000 && !io_ready; i++) @(negedge CLK);
    if (!io_ready) return;
    io_read_req = 1'b1;
    @(negedge CLK);
    io_read_req = 1'b0;
    ok = io_done;
    d = io_rdata;
    @(negedge CLK);
    ok = ok && !io_done;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({io_ready, io_done, io_rdata, frame_err, overrun_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b done=%b rdata=%h ferr=%b oerr=%b want all 0",
               io_ready, io_done, io_rdata, frame_err, overrun_err);
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    send_frame(8'hA5, 1'b1);
    checks++;
    if (io_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", io_ready); end
    io_read_req = 1'b1;
    @(negedge CLK);
    io_read_req = 1'b0;
    checks++;
    if (io_done !== 1'b1 || io_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL single_done: got done=%b rdata=%h want 1/a5", io_done, io_rdata);
    end
    @(negedge CLK);
    checks++;
    if (io_done !== 1'b0 || io_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_after: got done=%b rdy=%b want 0/0", io_done, io_ready);
    end
    repeat (100) @(negedge CLK);
    checks++;
    if (io_rdata !== 8'hA5) begin failures++; $display("FAIL single_hold: got %h want a5", io_rdata); end
  endtask

  task automatic test_stream();
    logic [7:0] d;
    bit ok;
    do_reset();
    fork
      for (int i = 0; i < 10; i++) send_frame(stream[i], 1'b1);
      for (int j = 0; j < 10; j++) begin
        read_byte(d, ok);
        checks++;
        if (!ok || d !== stream[j]) begin
          failures++;
          $display("FAIL stream_byte%0d: got %h ok=%b want %h", j, d, ok, stream[j]);
        end
      end
    join
    checks++;
    if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      failures++;
      $display("FAIL stream_errs: got ferr=%b oerr=%b want 0/0", frame_err, overrun_err);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    checks++;
    if (overrun_err !== 1'b0) begin failures++; $display("FAIL overrun_full_ok: got %b want 0", overrun_err); end
    send_frame(8'h14, 1'b1);
    checks++;
    if (overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b want 1", overrun_err); end
    for (int i = 0; i < 4; i++) begin
      read_byte(d, ok);
      checks++;
      if (!ok || d !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL overrun_read%0d: got %h ok=%b want %h", i, d, ok, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (io_ready !== 1'b0) begin failures++; $display("FAIL overrun_drained: got rdy=%b want 0", io_ready); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    bit ok;
    do_reset();
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge CLK);
    checks++;
    if (frame_err !== 1'b1 || io_ready !== 1'b0) begin
      failures++;
      $display("FAIL frame_err: got ferr=%b rdy=%b want 1/0", frame_err, io_ready);
    end
    send_frame(8'h55, 1'b1);
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h55 || frame_err !== 1'b1) begin
      failures++;
      $display("FAIL frame_recover: got %h ok=%b ferr=%b want 55/1/1", d, ok, frame_err);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    RXD = 1'b0;
    repeat (6) @(negedge CLK);
    RXD = 1'b1;
    repeat (40) @(negedge CLK);
    checks++;
    if (io_ready !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0 || dut.state !== 2'd0) begin
      failures++;
      $display("FAIL glitch: got rdy=%b ferr=%b oerr=%b state=%0d want 0/0/0/0",
               io_ready, frame_err, overrun_err, dut.state);
    end
  endtask

  task automatic test_req_edges();
    logic [7:0] d;
    bit ok;
    int dones;
    do_reset();
    dones = 0;
    io_read_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (io_done) dones++;
    end
    io_read_req = 1'b0;
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL req_empty: got %0d dones want 0", dones); end
    send_frame(8'h11, 1'b1);
    // the pop is timed to land on the same edge that pushes 0x22
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(negedge CLK);
        io_read_req = 1'b1;
        @(negedge CLK);
        io_read_req = 1'b0;
        checks++;
        if (io_done !== 1'b1 || io_rdata !== 8'h11 || dut.u_fifo.count !== 3'd1) begin
          failures++;
          $display("FAIL push_pop: got done=%b rdata=%h count=%0d want 1/11/1",
                   io_done, io_rdata, dut.u_fifo.count);
        end
      end
    join
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h22 || io_ready !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_tail: got %h ok=%b rdy=%b want 22/1/0", d, ok, io_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    bit ok;
    do_reset();
    send_frame(8'hAA, 1'b1);
    send_frame(8'hBB, 1'b1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (88) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
    join
    checks++;
    if (io_ready !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0 || io_rdata !== 8'h00) begin
      failures++;
      $display("FAIL midreset: got rdy=%b ferr=%b oerr=%b rdata=%h want 0/0/0/00",
               io_ready, frame_err, overrun_err, io_rdata);
    end
    send_frame(8'h81, 1'b1);
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h81) begin failures++; $display("FAIL midreset_next: got %h ok=%b want 81", d, ok); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stream();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_req_edges();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_byte_io.md
Name: uart_rx_byte_io

Overview:
- UART receiver plus small byte FIFO.
- Deserialises the board RX line and presents received bytes on the request/ready/done byte-read handshake.
- The boot loader consumes this handshake to pull its length prefix and payload.
- Replaces the AXI-UART path: the loader reads one byte per handshake with no bus master involved.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Must be >= 4.
- FIFO_DEPTH, 16: byte FIFO entries. Power of two, >= 2.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- RXD  in  1  asynchronous UART line, idle high, 8N1, LSB first
- io_read_req  in  1  consumer requests one byte; sampled on CLK
- io_ready  out  1  a byte is available and no read is in progress
- io_done  out  1  one-cycle pulse; io_rdata is valid this cycle
- io_rdata  out  8  byte delivered with io_done; held until the next read
- frame_err  out  1  sticky: a stop bit was sampled low
- overrun_err  out  1  sticky: a byte arrived while the FIFO was full

Behaviour:
- Reset and clock: one clock domain. RST is synchronous, active-high, and has priority over everything.
- Reset state:
  - RX FSM in IDLE; FIFO emptied.
  - io_done=0, io_rdata=0x00, io_ready=0, frame_err=0, overrun_err=0.
  - Synchroniser flops preset to 1.
- Reset mid-frame: the partial byte is discarded and the FSM does not resume.
- Input sync: RXD passes through a 2-FF synchroniser. All RX logic uses the synchronised value (2-cycle input lag).
- RX FSM (bit counter 0..CLKS_PER_BIT-1, bit index 0..7):
  - IDLE: on synchronised RXD==0, load the counter and go to START.
  - START: wait CLKS_PER_BIT/2 (integer divide) cycles, then sample.
    - Sample 0: go to DATA, bit index=0.
    - Sample 1: glitch; return to IDLE, nothing recorded.
  - DATA: every CLKS_PER_BIT cycles, sample into shift[bit index], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - Sample 1: push the byte.
    - Sample 0: set frame_err, drop the byte.
    - Either way, return to IDLE in the same cycle so a back-to-back start bit is caught.
- FIFO push: if full, drop the byte and set overrun_err. Existing contents are untouched.
- Read handshake:
  - io_ready = !fifo_empty && !io_done. Combinational from registered state.
  - A read is accepted on a rising edge where io_read_req && io_ready.
  - On acceptance: at that edge io_rdata <= FIFO head, io_done <= 1, head popped. io_done falls on the next edge.
  - Latency is 1 cycle from the accepting edge.
  - io_read_req while !io_ready is ignored; no queuing, no error.
  - io_read_req held high: at most one pop per 2 cycles, because io_done masks io_ready.
- Simultaneous push and pop in one cycle: both happen and the count is unchanged.
- Push into an empty FIFO: io_ready rises the cycle after the push edge.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits: full = count==FIFO_DEPTH, empty = count==0.
- Error flags clear only on RST.

Decomposition:
- Shared package (uart_pkg):
  - RX state encoding: IDLE, START, DATA, STOP as 2-bit localparams.
  - Default CLKS_PER_BIT.
  - Error-code constants for frame and overrun, matching the loader's 8-bit err numbering style.
- Sub-module byte_fifo, parameterised on depth:
  - Inputs: push, push_data, pop.
  - Outputs: head, empty, full.
  - Synchronous, first-word not registered-ahead (head = mem[rd_ptr]).
- The top level holds the synchroniser, the RX FSM and the handshake logic.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Single byte: send 0xA5 and wait. io_ready=1 within 3 cycles of the stop-bit sample. Pulse io_read_req 1 cycle. io_done=1 exactly 1 cycle later with io_rdata=0xA5. io_ready=0 afterwards. io_rdata still 0xA5 100 cycles later.
- Loader-style stream: send 0x00, 0x08, then 0xDE, 0xAD, 0xBE, 0xEF, 0x01, 0x02, 0x03, 0x04 back-to-back. Drive the loader handshake (req 1 cycle, wait done, re-check ready). All 10 bytes return in order, frame_err=0, overrun_err=0.
- Overrun: send 5 bytes 0x10..0x14 without reading. overrun_err=1 after the 5th stop bit. Reads return 0x10..0x13, then io_ready=0.
- Frame error: send 0x3C with the stop bit forced low. frame_err=1, io_ready stays 0. A following valid 0x55 is received normally.
- Glitch and request edge cases:
  - RXD low for 6 cycles: no byte, no error, FSM back in IDLE.
  - io_read_req held high with FIFO empty: no io_done.
  - Push and pop in the same cycle with the FIFO holding 1 byte: count unchanged.
- Reset mid-frame: assert RST for 1 cycle during data bit 4 of 0xF0, with 2 bytes queued. Afterwards io_ready=0 and both errors are 0. The next byte 0x81 is received correctly.
